// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: one input stream routed per word by in_sel to four channels.
// Latency 1 cycle, 1 word/cycle; a full, undrained channel stalls only words addressed to it.
// Optional per-channel saturating word counters are built when DEMUX_CNT_EN is defined.
module demux_1to4_reg #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic [WIDTH-1:0]     out_c,
    output logic [WIDTH-1:0]     out_d,
    output logic                 a_valid,
    output logic                 b_valid,
    output logic                 c_valid,
    output logic                 d_valid,
    input  logic                 a_ready,
    input  logic                 b_ready,
    input  logic                 c_ready,
    input  logic                 d_ready,
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b,
    output logic [CNT_WIDTH-1:0] cnt_c,
    output logic [CNT_WIDTH-1:0] cnt_d
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q [4];
    state_t           state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [3:0]       rdy;
    logic [3:0]       vld;
    logic             accept;

    assign rdy = {d_ready, c_ready, b_ready, a_ready};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            vld[i] = (state_q[i] == FULL);
        end
    end

    // Readiness depends only on the addressed channel, never on in_data.
    assign in_ready = ~vld[in_sel] | rdy[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                EMPTY: if (accept && in_sel == 2'(i)) state_d[i] = FULL;
                FULL:  if (rdy[i] && !(accept && in_sel == 2'(i))) state_d[i] = EMPTY;
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
            end
            if (accept) begin
                data_q[in_sel] <= in_data;
            end
        end
    end

    assign out_a   = data_q[0];
    assign out_b   = data_q[1];
    assign out_c   = data_q[2];
    assign out_d   = data_q[3];
    assign a_valid = vld[0];
    assign b_valid = vld[1];
    assign c_valid = vld[2];
    assign d_valid = vld[3];

`ifdef DEMUX_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [4];

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (accept && cnt_q[in_sel] != {CNT_WIDTH{1'b1}}) begin
            cnt_q[in_sel] <= cnt_q[in_sel] + 1'b1;
        end
    end

    assign cnt_a = cnt_q[0];
    assign cnt_b = cnt_q[1];
    assign cnt_c = cnt_q[2];
    assign cnt_d = cnt_q[3];
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
    assign cnt_c = '0;
    assign cnt_d = '0;
`endif

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Bench for demux_1to4_reg: directed scenarios plus randomized traffic against a per-channel
// "holding a word or not" reference model.
module tb_demux_1to4_reg;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_a, out_b, out_c, out_d;
    logic          a_valid, b_valid, c_valid, d_valid;
    logic [3:0]    rdy_v;
    logic [CW-1:0] cnt_a, cnt_b, cnt_c, cnt_d;

    logic [W-1:0]  outv [4];
    logic [3:0]    vldv;
    logic [CW-1:0] cntv [4];

    bit            mfull [4];
    logic [W-1:0]  mout  [4];
    int            mcnt  [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_1to4_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
        .a_ready(rdy_v[0]), .b_ready(rdy_v[1]), .c_ready(rdy_v[2]), .d_ready(rdy_v[3]),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
    );

    assign outv[0] = out_a;
    assign outv[1] = out_b;
    assign outv[2] = out_c;
    assign outv[3] = out_d;
    assign vldv    = {d_valid, c_valid, b_valid, a_valid};
    assign cntv[0] = cnt_a;
    assign cntv[1] = cnt_b;
    assign cntv[2] = cnt_c;
    assign cntv[3] = cnt_d;

    // A channel can take a word if it holds nothing or its consumer takes the held word now.
    function automatic logic exp_in_ready();
        return !mfull[in_sel] || rdy_v[in_sel];
    endfunction

    function automatic logic [CW-1:0] exp_cnt(input int ch);
`ifdef DEMUX_CNT_EN
        return CW'((mcnt[ch] > CMAX) ? CMAX : mcnt[ch]);
`else
        return '0;
`endif
    endfunction

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic tick();
        logic can;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mfull[i] = 1'b0;
                mout[i]  = '0;
                mcnt[i]  = 0;
            end
        end else begin
            can = exp_in_ready();
            for (int i = 0; i < 4; i++) begin
                if (mfull[i] && rdy_v[i]) mfull[i] = 1'b0;
            end
            if (in_valid && can) begin
                mfull[in_sel] = 1'b1;
                mout[in_sel]  = in_data;
                mcnt[in_sel]  = mcnt[in_sel] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; rdy_v = 4'hF;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (vldv[i] !== 1'b0) begin
                n_err++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, vldv[i]);
            end
            n_cmp++;
            if (outv[i] !== 8'h00) begin
                n_err++; $display("FAIL reset_out[%0d]: got %h expected 00", i, outv[i]);
            end
            n_cmp++;
            if (cntv[i] !== '0) begin
                n_err++; $display("FAIL reset_cnt[%0d]: got %h expected 0", i, cntv[i]);
            end
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pat [4];
        pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hF0; pat[3] = 8'h0F;
        rdy_v = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = pat[i]; in_sel = 2'(i);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            tick();
            n_cmp++;
            if (outv[i] !== pat[i]) begin
                n_err++; $display("FAIL b2b_out[%0d]: got %h expected %h", i, outv[i], pat[i]);
            end
            n_cmp++;
            if (vldv !== (4'b1 << i)) begin
                n_err++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, vldv, 4'b1 << i);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (vldv !== 4'b0000) begin
            n_err++; $display("FAIL b2b_drained: got %b expected 0000", vldv);
        end
    endtask

    task automatic test_stall();
        rdy_v = 4'hE;
        in_valid = 1'b1; in_data = 8'h11; in_sel = 2'd0;
        tick();
        in_data = 8'h22;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        tick();
        n_cmp++;
        if (out_a !== 8'h11 || a_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_hold_a: got %h/%b expected 11/1", out_a, a_valid);
        end
        in_data = 8'h33; in_sel = 2'd1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_other_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_b !== 8'h33 || b_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_b: got %h/%b expected 33/1", out_b, b_valid);
        end
        n_cmp++;
        if (out_a !== 8'h11 || a_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_a_kept: got %h/%b expected 11/1", out_a, a_valid);
        end
    endtask

    task automatic test_no_bubble();
        rdy_v = 4'hF;
        in_valid = 1'b1; in_data = 8'h44; in_sel = 2'd0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL nobub_in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_a !== 8'h44 || a_valid !== 1'b1) begin
            n_err++; $display("FAIL nobub_a: got %h/%b expected 44/1", out_a, a_valid);
        end
        tick();
        n_cmp++;
        if (out_a !== 8'h44 || a_valid !== 1'b0) begin
            n_err++; $display("FAIL nobub_drain: got %h/%b expected 44/0", out_a, a_valid);
        end
    endtask

    task automatic test_mid_reset();
        rdy_v = 4'hB;
        in_valid = 1'b1; in_data = 8'h55; in_sel = 2'd2;
        tick();
        n_cmp++;
        if (out_c !== 8'h55 || c_valid !== 1'b1) begin
            n_err++; $display("FAIL mrst_fill_c: got %h/%b expected 55/1", out_c, c_valid);
        end
        rst = 1'b1; in_data = 8'h77; in_sel = 2'd0;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_c !== 8'h00 || c_valid !== 1'b0) begin
            n_err++; $display("FAIL mrst_c: got %h/%b expected 00/0", out_c, c_valid);
        end
        n_cmp++;
        if (out_a !== 8'h00 || a_valid !== 1'b0) begin
            n_err++; $display("FAIL mrst_no_accept: got %h/%b expected 00/0", out_a, a_valid);
        end
    endtask

    task automatic test_counters();
        rdy_v = 4'hF;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; in_sel = 2'd3; in_data = 8'($urandom);
            tick();
            n_cmp++;
            if (cnt_d !== exp_cnt(3)) begin
                n_err++; $display("FAIL cnt_d_step[%0d]: got %h expected %h", k, cnt_d, exp_cnt(3));
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
`ifdef DEMUX_CNT_EN
        if (cnt_d !== 4'hF) begin
            n_err++; $display("FAIL cnt_d_sat: got %h expected f", cnt_d);
        end
`else
        if (cnt_d !== 4'h0) begin
            n_err++; $display("FAIL cnt_d_off: got %h expected 0", cnt_d);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cntv[i] !== exp_cnt(i)) begin
                n_err++; $display("FAIL cnt_other[%0d]: got %h expected %h", i, cntv[i], exp_cnt(i));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 2'($urandom);
            in_data  = 8'($urandom);
            rdy_v    = 4'($urandom);
            #1;
            n_cmp++;
            if (in_ready !== exp_in_ready()) begin
                n_err++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", k, in_ready, exp_in_ready());
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (vldv[i] !== mfull[i] || outv[i] !== mout[i] || cntv[i] !== exp_cnt(i)) begin
                    n_err++;
                    $display("FAIL rand_ch[%0d][%0d]: got v=%b d=%h c=%h expected v=%b d=%h c=%h",
                             k, i, vldv[i], outv[i], cntv[i], mfull[i], mout[i], exp_cnt(i));
                end
            end
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_no_bubble();
        test_mid_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        test_counters();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
